// File: rtl/debugger_apb_sequencer.sv
// APB completer that walks the debugger microcode table one STEP per access cycle.
// Completes when the microcode row signals ready, or with PSLVERR once STEP_LIMIT is reached.
module debugger_apb_sequencer #(
    parameter int STEP_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [4:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic       PREADY,
    output logic [7:0] PRDATA,
    output logic       PSLVERR,
    output logic [4:0] ADDR,
    output logic       WRITE,
    output logic [1:0] STEP,
    input  logic       mc_pready,
    input  logic       mc_paddr_or_pwdata,
    input  logic       mc_outreg_or_bus,
    input  logic [7:0] bus_in,
    output logic [7:0] dbg_bus_out,
    output logic       dbg_bus_oe,
    output logic       dbg_state_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam logic [1:0] STEP_LAST = 2'(STEP_LIMIT);

    state_e     state_q;
    logic [4:0] addr_q;
    logic       write_q;
    logic [7:0] wdata_q;
    logic [1:0] step_q;
    logic [7:0] outreg_q;

    logic in_access;
    logic xfer_active;
    logic timeout;

    // Handshake: a setup cycle (PSEL=1, PENABLE=0) in IDLE opens a transfer; each
    // access cycle (PSEL=1, PENABLE=1) either completes with PREADY=1 or advances
    // STEP. Any access cycle without PSEL&PENABLE abandons the transfer silently.
    assign in_access   = (state_q == ACCESS);
    assign xfer_active = in_access && PSEL && PENABLE;
    assign timeout     = in_access && (step_q == STEP_LAST) && !mc_pready;

    assign PREADY  = xfer_active && (mc_pready || timeout);
    assign PSLVERR = PREADY && timeout;
    assign PRDATA  = (PREADY && !write_q) ? (mc_outreg_or_bus ? outreg_q : bus_in) : 8'h00;

    // Outside a transfer, point the microcode at its spare row so no control fires.
    assign ADDR        = in_access ? addr_q : 5'h1F;
    assign WRITE       = in_access ? write_q : 1'b1;
    assign STEP        = in_access ? step_q : 2'd3;
    assign dbg_bus_oe  = in_access;
    assign dbg_bus_out = !in_access ? 8'h00 :
                         (mc_paddr_or_pwdata ? {3'b000, addr_q} : wdata_q);
    assign dbg_state_o = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= 5'h00;
            write_q  <= 1'b0;
            wdata_q  <= 8'h00;
            step_q   <= 2'd0;
            outreg_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        step_q  <= 2'd0;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!PREADY) begin
                        outreg_q <= bus_in;
                    end
                    if (!xfer_active) begin
                        step_q  <= 2'd0;
                        state_q <= IDLE;
                    end else if (PREADY) begin
                        step_q  <= 2'd0;
                        state_q <= IDLE;
                    end else begin
                        step_q <= step_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debugger_apb_sequencer.sv
// Directed bench for debugger_apb_sequencer with a small microcode responder:
// rows 0x00-0x07 ready at STEP 0, rows 0x08-0x18 ready at STEP 1, others never.
module tb_debugger_apb_sequencer;

    logic       clk;
    logic       rst_n;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [4:0] PADDR;
    logic [7:0] PWDATA;
    logic       PREADY;
    logic [7:0] PRDATA;
    logic       PSLVERR;
    logic [4:0] ADDR;
    logic       WRITE;
    logic [1:0] STEP;
    logic       mc_pready;
    logic       mc_paddr_or_pwdata;
    logic       mc_outreg_or_bus;
    logic [7:0] bus_in;
    logic [7:0] dbg_bus_out;
    logic       dbg_bus_oe;
    logic       dbg_state_o;

    int n_total = 0;
    int n_bad   = 0;

    debugger_apb_sequencer #(.STEP_LIMIT(3)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .PSEL               (PSEL),
        .PENABLE            (PENABLE),
        .PWRITE             (PWRITE),
        .PADDR              (PADDR),
        .PWDATA             (PWDATA),
        .PREADY             (PREADY),
        .PRDATA             (PRDATA),
        .PSLVERR            (PSLVERR),
        .ADDR               (ADDR),
        .WRITE              (WRITE),
        .STEP               (STEP),
        .mc_pready          (mc_pready),
        .mc_paddr_or_pwdata (mc_paddr_or_pwdata),
        .mc_outreg_or_bus   (mc_outreg_or_bus),
        .bus_in             (bus_in),
        .dbg_bus_out        (dbg_bus_out),
        .dbg_bus_oe         (dbg_bus_oe),
        .dbg_state_o        (dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // microcode responder
    assign mc_pready          = (ADDR <= 5'h07) || ((ADDR <= 5'h18) && (STEP >= 2'd1));
    assign mc_paddr_or_pwdata = ~WRITE;
    assign mc_outreg_or_bus   = (STEP != 2'd0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_addr"}, 32'(ADDR), 32'h1F);
        check({tag, "_write"}, 32'(WRITE), 32'h1);
        check({tag, "_step"}, 32'(STEP), 32'h3);
        check({tag, "_oe"}, 32'(dbg_bus_oe), 32'h0);
        check({tag, "_busout"}, 32'(dbg_bus_out), 32'h0);
        check({tag, "_pready"}, 32'(PREADY), 32'h0);
        check({tag, "_pslverr"}, 32'(PSLVERR), 32'h0);
        check({tag, "_prdata"}, 32'(PRDATA), 32'h0);
        check({tag, "_state"}, 32'(dbg_state_o), 32'h0);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        #1 check_idle("idle");
    endtask

    // Setup cycle then ncyc access cycles; bus_in holds 'bus' during STEP 0 and ~bus afterwards.
    task automatic xfer(input logic wr, input logic [4:0] a, input logic [7:0] wd,
                        input logic [7:0] bus, input int ncyc,
                        input logic [7:0] exp_rd, input logic exp_err);
        logic last;
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; bus_in = bus;
        #1;
        check("setup_addr", 32'(ADDR), 32'h1F);
        check("setup_pready", 32'(PREADY), 32'h0);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            PENABLE = 1'b1;
            if (i > 0) bus_in = ~bus;
            #1;
            last = (i == ncyc - 1);
            check("acc_step", 32'(STEP), 32'(i));
            check("acc_addr", 32'(ADDR), 32'(a));
            check("acc_write", 32'(WRITE), 32'(wr));
            check("acc_oe", 32'(dbg_bus_oe), 32'h1);
            check("acc_busout", 32'(dbg_bus_out), wr ? 32'(wd) : 32'(a));
            check("acc_pready", 32'(PREADY), 32'(last));
            check("acc_pslverr", 32'(PSLVERR), 32'(last && exp_err));
            check("acc_prdata", 32'(PRDATA), (last && !wr) ? 32'(exp_rd) : 32'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 5'h00; PWDATA = 8'h00; bus_in = 8'h00;
        #12;
        check_idle("reset");
        @(negedge clk) rst_n = 1'b1;

        // single-cycle write
        xfer(1'b1, 5'h01, 8'h5A, 8'h00, 1, 8'h00, 1'b0);
        go_idle();
        // two-cycle read returns outreg captured at STEP 0
        xfer(1'b0, 5'h08, 8'h00, 8'h3C, 2, 8'h3C, 1'b0);
        go_idle();
        // boundary rows
        xfer(1'b0, 5'h07, 8'h00, 8'h7E, 1, 8'h7E, 1'b0);
        go_idle();
        xfer(1'b0, 5'h18, 8'h00, 8'h81, 2, 8'h81, 1'b0);
        go_idle();
        xfer(1'b1, 5'h12, 8'hA5, 8'h00, 2, 8'h00, 1'b0);
        go_idle();
        // unmapped row times out at STEP 3; outreg holds ~0x11 captured at STEP 2
        xfer(1'b0, 5'h1C, 8'h00, 8'h11, 4, 8'hEE, 1'b1);
        go_idle();

        // PSEL&PENABLE in IDLE without a setup
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = 5'h03;
        #1 check("proterr_pready", 32'(PREADY), 32'h0);
        @(posedge clk); #2;
        check("proterr_stay", 32'(dbg_state_o), 32'h0);
        go_idle();

        // requester abort: PENABLE stays low in the first access cycle
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 5'h0A;
        @(posedge clk); #2;
        check("abort_step", 32'(STEP), 32'h0);
        check("abort_pready", 32'(PREADY), 32'h0);
        check("abort_pslverr", 32'(PSLVERR), 32'h0);
        go_idle();

        // reset mid-transfer at STEP 1 of a write
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h10; PWDATA = 8'h77;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(posedge clk); #1;
        check("rst_pre_step", 32'(STEP), 32'h1);
        PENABLE = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_idle("async_rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #2;
        check("rst_after_pready", 32'(PREADY), 32'h0);
        check("rst_after_state", 32'(dbg_state_o), 32'h0);
        go_idle();

        // back-to-back reads: second setup lands in the cycle after the first PREADY
        xfer(1'b0, 5'h02, 8'h00, 8'h42, 1, 8'h42, 1'b0);
        xfer(1'b0, 5'h09, 8'h00, 8'h90, 2, 8'h90, 1'b0);
        go_idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
